// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage between EX/MEM and MEM/WB.
// Performs byte-addressed little-endian loads/stores of 1/2/4/8 bytes against
// an internal byte array with a fixed latency of MEM_LAT cycles. The stage
// stalls upstream while an access is in flight and pulses mem_done_out for
// one cycle when it completes.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   addr_in        byte address (wraps modulo DEPTH_BYTES, per byte)
//   wdata_in       store data
//   funct3_in      size/sign: b, h, w, d, bu, hu, wu (111 acts as d)
//   mem_read_in    load request
//   mem_write_in   store request (wins over a simultaneous load)
//   read_data_out  extended load data, held until the next load completes
//   stall_out      freeze the upstream pipeline
//   mem_done_out   one-cycle completion pulse
//   misalign_out   misaligned-access flag in the DONE cycle
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to suppress misaligned
// accesses (no write, load result 0) and flag them on misalign_out.
// Without it misaligned accesses are performed bytewise and misalign_out is 0.

module mem_access_stage #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  output logic [63:0] read_data_out,
  output logic        stall_out,
  output logic        mem_done_out,
  output logic        misalign_out
);

  localparam int unsigned AW   = $clog2(DEPTH_BYTES);
  localparam int unsigned CntW = (MEM_LAT > 8) ? $clog2(MEM_LAT) : 3;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      mem_q [DEPTH_BYTES];
  logic [63:0]     read_data_q;
  logic            misalign_q;

  logic            req;
  logic            commit;     // this edge enters DONE
  logic            misalign;
  logic [7:0]      byte_en;
  logic [AW-1:0]   byte_idx [8];
  logic [63:0]     raw;
  logic [63:0]     ext;
  logic            unused_addr;

  assign req         = mem_read_in | mem_write_in;
  assign unused_addr = ^addr_in[63:AW];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (MEM_LAT == 1) begin
            state_d = StDone;
            commit  = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(MEM_LAT - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    stall_out    = 1'b0;
    mem_done_out = 1'b0;
    unique case (state_q)
      StIdle:  stall_out = req;
      StBusy:  stall_out = 1'b1;
      StDone:  mem_done_out = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (funct3_in[1:0])
      2'b00:   byte_en = 8'h01;
      2'b01:   byte_en = 8'h03;
      2'b10:   byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end

  // Per-byte addresses wrap independently at the top of the array.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      byte_idx[i]    = addr_in[AW-1:0] + AW'(i);
      raw[8*i +: 8]  = mem_q[byte_idx[i]];
    end
  end

  always_comb begin
    unique case (funct3_in)
      3'b000:  ext = {{56{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
      3'b100:  ext = {56'd0, raw[7:0]};
      3'b101:  ext = {48'd0, raw[15:0]};
      3'b110:  ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    unique case (funct3_in[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_in[0];
      2'b10:   misalign = |addr_in[1:0];
      default: misalign = |addr_in[2:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Data array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && mem_write_in && !misalign) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) begin
          mem_q[byte_idx[i]] <= wdata_in[8*i +: 8];
        end
      end
    end
  end

  // A combined read+write request performs only the store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= commit & misalign;
      if (commit && mem_read_in && !mem_write_in) begin
        read_data_q <= misalign ? '0 : ext;
      end
    end
  end

  assign read_data_out = read_data_q;
  assign misalign_out  = misalign_q;

endmodule
